// File: rtl/tcb_scheduler_pkg.sv
// Shared ACFA constants: secure ROM bounds, scheduler state encodings,
// request source IDs and small helpers used by the TCB scheduler and the
// atomicity monitor.
package tcb_scheduler_pkg;

    localparam logic [15:0] SMEM_BASE_DEFAULT      = 16'hA000;
    localparam logic [15:0] LAST_SMEM_ADDR_DEFAULT = 16'hDFFE;
    localparam int          TIMER_WIDTH            = 16;

    localparam logic [1:0] SRC_CFLOG = 2'd0;
    localparam logic [1:0] SRC_VRF   = 2'd1;
    localparam logic [1:0] SRC_TIMER = 2'd2;
    localparam logic [1:0] SRC_NONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } tcbState_t;

    // Lowest source index wins: CF-log overflow is the most urgent.
    function automatic logic [1:0] pickSource(input logic [2:0] pending);
        logic [1:0] src;
        src = SRC_NONE;
        if (pending[0]) begin
            src = SRC_CFLOG;
        end else if (pending[1]) begin
            src = SRC_VRF;
        end else if (pending[2]) begin
            src = SRC_TIMER;
        end
        return src;
    endfunction

    // One-hot mask for a source ID; the idle ID maps to no bits.
    function automatic logic [2:0] srcOneHot(input logic [1:0] src);
        logic [2:0] mask;
        case (src)
            SRC_CFLOG: mask = 3'b001;
            SRC_VRF:   mask = 3'b010;
            SRC_TIMER: mask = 3'b100;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tcb_period_timer.sv
// Periodic attestation timer: counts 0..TIMER_PERIOD-1 while enabled and
// flags the wrap cycle, holding at zero while disabled.
module tcb_period_timer
    import tcb_scheduler_pkg::*;
#(
    parameter logic [TIMER_WIDTH-1:0] TIMER_PERIOD = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic timer_en,
    output logic expire
);

    logic [TIMER_WIDTH-1:0] r_count;
    logic                   w_lastCount;

    assign w_lastCount = (r_count == (TIMER_PERIOD - {{(TIMER_WIDTH-1){1'b0}}, 1'b1}));
    assign expire      = timer_en && w_lastCount;

    // Advance the period count, wrapping on the last count and parking at zero when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!timer_en || w_lastCount) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/tcb_scheduler.sv
// TCB scheduler: collects attestation requests from three sources, raises an
// interrupt for the highest-priority one and tracks the secure-ROM invocation
// from entry to a clean exit, reporting completion or abnormal termination.
module tcb_scheduler
    import tcb_scheduler_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE      = SMEM_BASE_DEFAULT,
    parameter logic [15:0] LAST_SMEM_ADDR = LAST_SMEM_ADDR_DEFAULT,
    parameter logic [15:0] TIMER_PERIOD   = 16'd50000,
    parameter logic [7:0]  PEND_TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        cflog_full,
    input  logic        vrf_req,
    input  logic        timer_en,
    output logic        irq_tcb,
    output logic [1:0]  tcb_src,
    output logic        tcb_busy,
    output logic [2:0]  src_ack,
    output logic        sched_err
);

    tcbState_t   r_state;
    tcbState_t   w_stateNext;

    logic        r_cflogPrev;
    logic        r_vrfPrev;
    logic [2:0]  r_pending;
    logic [2:0]  w_setMask;
    logic [2:0]  w_clearMask;
    logic [2:0]  w_pendingNext;

    logic [7:0]  r_toCnt;
    logic [7:0]  w_toCntNext;
    logic [7:0]  w_toCntInc;
    logic        r_sawLast;
    logic        w_sawLastNext;

    logic        r_irq;
    logic [1:0]  r_src;
    logic        r_busy;
    logic [2:0]  r_ack;
    logic        r_err;
    logic        w_irqNext;
    logic [1:0]  w_srcNext;
    logic        w_busyNext;
    logic [2:0]  w_ackNext;
    logic        w_errNext;

    logic        w_timerExpire;
    logic        w_pcInSmem;

    tcb_period_timer #(
        .TIMER_PERIOD (TIMER_PERIOD)
    ) u_periodTimer (
        .clk      (clk),
        .rst      (rst),
        .timer_en (timer_en),
        .expire   (w_timerExpire)
    );

    assign w_pcInSmem = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);
    assign w_toCntInc = r_toCnt + 8'd1;

    // A new request always wins over the clear of the same flag, so a request
    // landing in the completion cycle is not lost.
    assign w_setMask     = {w_timerExpire, vrf_req & ~r_vrfPrev, cflog_full & ~r_cflogPrev};
    assign w_pendingNext = (r_pending & ~w_clearMask) | w_setMask;

    assign irq_tcb   = r_irq;
    assign tcb_src   = r_src;
    assign tcb_busy  = r_busy;
    assign src_ack   = r_ack;
    assign sched_err = r_err;

    // Next-state and next-output decode; pulses default low so they last one cycle.
    always_comb begin
        w_stateNext   = r_state;
        w_irqNext     = r_irq;
        w_srcNext     = r_src;
        w_busyNext    = r_busy;
        w_ackNext     = 3'b000;
        w_errNext     = 1'b0;
        w_toCntNext   = r_toCnt;
        w_sawLastNext = r_sawLast;
        w_clearMask   = 3'b000;

        case (r_state)
            ST_IDLE: begin
                w_irqNext  = 1'b0;
                w_busyNext = 1'b0;
                w_srcNext  = SRC_NONE;
                if (|r_pending) begin
                    w_srcNext   = pickSource(r_pending);
                    w_irqNext   = 1'b1;
                    w_toCntNext = 8'd0;
                    w_stateNext = ST_PEND;
                end
            end
            ST_PEND: begin
                if (pc == SMEM_BASE) begin
                    w_irqNext     = 1'b0;
                    w_busyNext    = 1'b1;
                    w_sawLastNext = 1'b0;
                    w_stateNext   = ST_RUN;
                end else if (w_toCntInc == PEND_TIMEOUT) begin
                    w_toCntNext = w_toCntInc;
                    w_errNext   = 1'b1;
                    w_irqNext   = 1'b0;
                    w_srcNext   = SRC_NONE;
                    w_stateNext = ST_IDLE;
                end else begin
                    w_toCntNext = w_toCntInc;
                end
            end
            ST_RUN: begin
                if (!w_pcInSmem) begin
                    w_busyNext = 1'b0;
                    w_srcNext  = SRC_NONE;
                    if (r_sawLast) begin
                        w_ackNext   = srcOneHot(r_src);
                        w_clearMask = srcOneHot(r_src);
                        w_stateNext = ST_DONE;
                    end else begin
                        w_errNext   = 1'b1;
                        w_stateNext = ST_IDLE;
                    end
                end else if (pc == LAST_SMEM_ADDR) begin
                    w_sawLastNext = 1'b1;
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cflogPrev <= 1'b0;
            r_vrfPrev   <= 1'b0;
            r_pending   <= 3'b000;
            r_toCnt     <= 8'd0;
            r_sawLast   <= 1'b0;
            r_irq       <= 1'b0;
            r_src       <= SRC_NONE;
            r_busy      <= 1'b0;
            r_ack       <= 3'b000;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cflogPrev <= cflog_full;
            r_vrfPrev   <= vrf_req;
            r_pending   <= w_pendingNext;
            r_toCnt     <= w_toCntNext;
            r_sawLast   <= w_sawLastNext;
            r_irq       <= w_irqNext;
            r_src       <= w_srcNext;
            r_busy      <= w_busyNext;
            r_ack       <= w_ackNext;
            r_err       <= w_errNext;
        end
    end

endmodule
